// File: rtl/cmpx_mac_seq.sv
// Sequential complex multiply-accumulate: queues operand pairs in a 4-deep FIFO,
// then feeds them to an external multiplier and sums the products on go.
module cmpx_mac_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [7:0]         push_a,
  input  logic [7:0]         push_b,
  input  logic               go,
  output logic               mult_start,
  output logic [7:0]         mult_a,
  output logic [7:0]         mult_b,
  input  logic               mult_done,
  input  logic [15:0]        mult_out,
  output logic signed [10:0] acc_re,
  output logic signed [10:0] acc_im,
  output logic               busy,
  output logic               done,
  output logic               full,
  output logic               empty
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ACC   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]         r_state;
  logic [15:0]        r_mem [4];
  logic [1:0]         r_wr_ptr;
  logic [1:0]         r_rd_ptr;
  logic [2:0]         r_count;
  logic               r_wait_first;
  logic [7:0]         r_mult_a;
  logic [7:0]         r_mult_b;
  logic signed [10:0] r_acc_re;
  logic signed [10:0] r_acc_im;

  logic               w_full;
  logic               w_empty;
  logic               w_push_ok;
  logic [1:0]         w_rd_next;
  logic [15:0]        w_head;
  logic [15:0]        w_next_head;
  logic signed [10:0] w_prod_re;
  logic signed [10:0] w_prod_im;

  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  // go wins over a same-cycle push, so a push is only taken in IDLE without go.
  assign w_push_ok   = push && !go && !w_full && (r_state == IDLE);
  assign w_rd_next   = r_rd_ptr + 2'd1;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_next_head = r_mem[w_rd_next];
  assign w_prod_re   = {{3{mult_out[15]}}, mult_out[15:8]};
  assign w_prod_im   = {{3{mult_out[7]}},  mult_out[7:0]};

  // NOTE: the storage array has no reset; emptiness is tracked by r_count, so
  // clearing the data would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= {push_a, push_b};
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_wait_first <= 1'b0;
      r_mult_a     <= 8'd0;
      r_mult_b     <= 8'd0;
      r_acc_re     <= 11'sd0;
      r_acc_im     <= 11'sd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_acc_re <= 11'sd0;
            r_acc_im <= 11'sd0;
            if (!w_empty) begin
              r_state  <= ISSUE;
              r_mult_a <= w_head[15:8];
              r_mult_b <= w_head[7:0];
            end else begin
              r_state <= FIN;
            end
          end else if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
            r_count  <= r_count + 3'd1;
          end
        end
        ISSUE: begin
          r_state      <= WAIT;
          r_wait_first <= 1'b1;
        end
        WAIT: begin
          // The first WAIT cycle may still see the previous operation's done level.
          r_wait_first <= 1'b0;
          if (!r_wait_first && mult_done) r_state <= ACC;
        end
        ACC: begin
          r_acc_re <= r_acc_re + w_prod_re;
          r_acc_im <= r_acc_im + w_prod_im;
          r_rd_ptr <= w_rd_next;
          r_count  <= r_count - 3'd1;
          if (r_count > 3'd1) begin
            r_state  <= ISSUE;
            r_mult_a <= w_next_head[15:8];
            r_mult_b <= w_next_head[7:0];
          end else begin
            r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mult_start = (r_state == ISSUE);
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;
  assign acc_re     = r_acc_re;
  assign acc_im     = r_acc_im;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FIN);
  assign full       = w_full;
  assign empty      = w_empty;

endmodule
